// File: rtl/key_event_scheduler_pkg.sv
// Shared constants, key-index width helper and FSM state type for the key event scheduler.
package key_pkg;

    localparam int KEYS_DEFAULT = 61;

    localparam logic KEY_PRESSED  = 1'b0;
    localparam logic KEY_RELEASED = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    function automatic int key_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_event_scheduler_if.sv
// Key level inputs plus the press/release event valid/ready channel and status outputs.
interface key_event_scheduler_if import key_pkg::*; #(
    parameter int KEYS  = KEYS_DEFAULT,
    parameter int CNT_W = 16
);
    localparam int KEY_W = key_w(KEYS);

    logic [KEYS-1:0]  keys;
    logic             enable;
    logic             evt_valid;
    logic [KEY_W-1:0] evt_key;
    logic             evt_pressed;
    logic             evt_ready;
    logic             pending;
    logic [CNT_W-1:0] evt_count;
    logic             busy;

    modport master (
        input  keys, enable, evt_ready,
        output evt_valid, evt_key, evt_pressed, pending, evt_count, busy
    );

    modport slave (
        output keys, enable, evt_ready,
        input  evt_valid, evt_key, evt_pressed, pending, evt_count, busy
    );
endinterface

// File: rtl/key_event_scheduler_rr_pick.sv
// Combinational round-robin pick: lowest set request at or above ptr, else lowest overall.
module rr_pick import key_pkg::*; #(
    parameter int  KEYS  = KEYS_DEFAULT,
    localparam int KEY_W = key_w(KEYS)
) (
    input  logic [KEYS-1:0]  req,
    input  logic [KEY_W-1:0] ptr,
    output logic             any,
    output logic [KEY_W-1:0] idx
);
    logic             hi_any;
    logic             lo_any;
    logic [KEY_W-1:0] hi_idx;
    logic [KEY_W-1:0] lo_idx;

    // Downward scan so the last hit seen is the lowest index in each half.
    always_comb begin
        hi_any = 1'b0;
        lo_any = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = KEYS - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_any = 1'b1;
                lo_idx = KEY_W'(i);
                if (i >= int'(ptr)) begin
                    hi_any = 1'b1;
                    hi_idx = KEY_W'(i);
                end
            end
        end
    end

    assign any = lo_any;
    assign idx = hi_any ? hi_idx : lo_idx;
endmodule

// File: rtl/key_event_scheduler.sv
// Turns key level changes into one press/release event at a time; event valid one cycle after
// its change is seen, held stable under backpressure, at most one event per two cycles.
module key_event_scheduler import key_pkg::*; #(
    parameter int KEYS  = KEYS_DEFAULT,
    parameter int CNT_W = 16
) (
    input logic                    clk_i,
    input logic                    rst_i,
    key_event_scheduler_if.master  bus
);
    localparam int KEY_W = key_w(KEYS);

    state_t           state;
    state_t           state_nxt;
    logic [KEYS-1:0]  reported;
    logic [KEYS-1:0]  pending;
    logic [KEY_W-1:0] ptr;
    logic [KEY_W-1:0] win_idx;
    logic             win_any;
    logic [KEY_W-1:0] evt_key;
    logic             evt_pressed;
    logic [CNT_W-1:0] evt_count;
    logic             grant;
    logic             accept;

    assign pending = bus.keys ^ reported;

    rr_pick #(.KEYS(KEYS)) u_pick (
        .req (pending),
        .ptr (ptr),
        .any (win_any),
        .idx (win_idx)
    );

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.enable && win_any) begin
                    grant     = 1'b1;
                    state_nxt = OFFER;
                end
            end
            OFFER: begin
                if (bus.evt_ready) begin
                    accept    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            reported    <= '1;
            ptr         <= '0;
            evt_key     <= '0;
            evt_pressed <= 1'b0;
            evt_count   <= '0;
        end else begin
            if (grant) begin
                evt_key     <= win_idx;
                evt_pressed <= (bus.keys[win_idx] == KEY_PRESSED);
            end
            // Only the granted key's reported level moves; others keep their pending bits.
            if (accept) begin
                reported[evt_key] <= evt_pressed ? KEY_PRESSED : KEY_RELEASED;
                ptr               <= (evt_key == KEY_W'(KEYS - 1)) ? '0 : evt_key + 1'b1;
                evt_count         <= evt_count + 1'b1;
            end
        end
    end

    assign bus.evt_valid   = (state == OFFER);
    assign bus.busy        = (state == OFFER);
    assign bus.evt_key     = evt_key;
    assign bus.evt_pressed = evt_pressed;
    assign bus.evt_count   = evt_count;
    assign bus.pending     = |pending;
endmodule

// File: tb/tb_key_event_scheduler.sv
// Bench for key_event_scheduler and its standalone rr_pick, with a queue-free reference model.
module tb_key_event_scheduler;
    import key_pkg::*;

    localparam int KEYS  = 61;
    localparam int CNT_W = 16;
    localparam int KW    = key_w(KEYS);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    key_event_scheduler_if #(.KEYS(KEYS), .CNT_W(CNT_W)) bus ();

    key_event_scheduler #(.KEYS(KEYS), .CNT_W(CNT_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    logic [KEYS-1:0] pr_req;
    logic [KW-1:0]   pr_ptr;
    logic            pr_any;
    logic [KW-1:0]   pr_idx;

    rr_pick #(.KEYS(KEYS)) u_rr (
        .req (pr_req),
        .ptr (pr_ptr),
        .any (pr_any),
        .idx (pr_idx)
    );

    int tests = 0;
    int fails = 0;

    // Reference: scan KEYS positions starting at ptr, modulo KEYS; -1 when nothing requested.
    function automatic int ref_pick(input logic [KEYS-1:0] req, input int p);
        for (int k = 0; k < KEYS; k++) begin
            if (req[(p + k) % KEYS]) return (p + k) % KEYS;
        end
        return -1;
    endfunction

    logic [KEYS-1:0] m_rep;
    logic            m_valid;
    logic            m_pressed;
    int              m_key;
    int              m_ptr;
    int              m_cnt;
    int              m_w;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rep = '1; m_valid = 1'b0; m_pressed = 1'b0;
            m_key = 0; m_ptr = 0; m_cnt = 0;
        end else if (m_valid) begin
            if (bus.evt_ready) begin
                m_rep[m_key] = ~m_pressed;
                m_ptr        = (m_key + 1) % KEYS;
                m_cnt        = (m_cnt + 1) % (1 << CNT_W);
                m_valid      = 1'b0;
            end
        end else if (bus.enable) begin
            m_w = ref_pick(bus.keys ^ m_rep, m_ptr);
            if (m_w >= 0) begin
                m_valid   = 1'b1;
                m_key     = m_w;
                m_pressed = ~bus.keys[m_w];
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.keys      = '1;
        bus.enable    = 1'b1;
        bus.evt_ready = 1'b0;
        repeat (2) cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({bus.evt_valid, bus.evt_key, bus.evt_pressed, bus.busy} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: valid=%0b key=%0d pressed=%0b busy=%0b, want all 0",
                     bus.evt_valid, bus.evt_key, bus.evt_pressed, bus.busy);
        end
        bus.evt_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            cyc();
            tests++;
            if (bus.evt_valid !== 1'b0 || bus.pending !== 1'b0 || bus.evt_count !== '0) begin
                fails++;
                $display("FAIL reset_idle c%0d: valid=%0b pending=%0b count=%0d, want 0/0/0",
                         c, bus.evt_valid, bus.pending, bus.evt_count);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        bus.evt_ready = 1'b1;
        bus.keys[5]   = 1'b0;
        cyc();
        tests++;
        if (bus.evt_valid !== 1'b1 || bus.evt_key !== KW'(5) || bus.evt_pressed !== 1'b1) begin
            fails++;
            $display("FAIL single_press: valid=%0b key=%0d pressed=%0b, want 1/5/1",
                     bus.evt_valid, bus.evt_key, bus.evt_pressed);
        end
        cyc();
        tests++;
        if (bus.evt_valid !== 1'b0 || bus.evt_count !== CNT_W'(1) || bus.pending !== 1'b0) begin
            fails++;
            $display("FAIL single_accept: valid=%0b count=%0d pending=%0b, want 0/1/0",
                     bus.evt_valid, bus.evt_count, bus.pending);
        end
        bus.keys[5] = 1'b1;
        cyc();
        tests++;
        if (bus.evt_valid !== 1'b1 || bus.evt_key !== KW'(5) || bus.evt_pressed !== 1'b0) begin
            fails++;
            $display("FAIL single_release: valid=%0b key=%0d pressed=%0b, want 1/5/0",
                     bus.evt_valid, bus.evt_key, bus.evt_pressed);
        end
        cyc();
        tests++;
        if (bus.evt_count !== CNT_W'(2) || bus.pending !== 1'b0) begin
            fails++;
            $display("FAIL single_count2: count=%0d pending=%0b, want 2/0", bus.evt_count, bus.pending);
        end
    endtask

    task automatic test_back_to_back();
        int exp_k;
        logic exp_v;
        do_reset();
        bus.evt_ready = 1'b1;
        bus.keys[3]   = 1'b0;
        bus.keys[40]  = 1'b0;
        bus.keys[60]  = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            cyc();
            exp_v = (c == 1 || c == 3 || c == 5);
            exp_k = (c == 1) ? 3 : (c == 3) ? 40 : 60;
            tests++;
            if (bus.evt_valid !== exp_v || (exp_v && bus.evt_key !== KW'(exp_k))) begin
                fails++;
                $display("FAIL b2b c%0d: valid=%0b key=%0d, want %0b/%0d",
                         c, bus.evt_valid, bus.evt_key, exp_v, exp_k);
            end
        end
        tests++;
        if (bus.evt_count !== CNT_W'(3)) begin
            fails++;
            $display("FAIL b2b_count: count=%0d, want 3", bus.evt_count);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        bus.evt_ready = 1'b1;
        bus.keys[59]  = 1'b0;
        cyc();
        tests++;
        if (bus.evt_valid !== 1'b1 || bus.evt_key !== KW'(59)) begin
            fails++;
            $display("FAIL wrap_59: valid=%0b key=%0d, want 1/59", bus.evt_valid, bus.evt_key);
        end
        cyc();
        bus.keys[0]  = 1'b0;
        bus.keys[60] = 1'b0;
        cyc();
        tests++;
        if (bus.evt_valid !== 1'b1 || bus.evt_key !== KW'(60)) begin
            fails++;
            $display("FAIL wrap_60: valid=%0b key=%0d, want 1/60", bus.evt_valid, bus.evt_key);
        end
        cyc();
        cyc();
        tests++;
        if (bus.evt_valid !== 1'b1 || bus.evt_key !== KW'(0)) begin
            fails++;
            $display("FAIL wrap_0: valid=%0b key=%0d, want 1/0", bus.evt_valid, bus.evt_key);
        end
    endtask

    task automatic test_hold();
        do_reset();
        bus.evt_ready = 1'b0;
        bus.keys[7]   = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            cyc();
            tests++;
            if (bus.evt_valid !== 1'b1 || bus.evt_key !== KW'(7) || bus.evt_pressed !== 1'b1) begin
                fails++;
                $display("FAIL hold c%0d: valid=%0b key=%0d pressed=%0b, want 1/7/1",
                         c, bus.evt_valid, bus.evt_key, bus.evt_pressed);
            end
            if (c == 4) bus.keys[7] = 1'b1;
        end
        bus.evt_ready = 1'b1;
        cyc();
        tests++;
        if (bus.evt_valid !== 1'b0 || bus.evt_count !== CNT_W'(1) || bus.pending !== 1'b1) begin
            fails++;
            $display("FAIL hold_accept: valid=%0b count=%0d pending=%0b, want 0/1/1",
                     bus.evt_valid, bus.evt_count, bus.pending);
        end
        cyc();
        tests++;
        if (bus.evt_valid !== 1'b1 || bus.evt_key !== KW'(7) || bus.evt_pressed !== 1'b0) begin
            fails++;
            $display("FAIL hold_release: valid=%0b key=%0d pressed=%0b, want 1/7/0",
                     bus.evt_valid, bus.evt_key, bus.evt_pressed);
        end
    endtask

    task automatic test_enable_reset();
        do_reset();
        bus.enable    = 1'b0;
        bus.evt_ready = 1'b1;
        bus.keys[10]  = 1'b0;
        bus.keys[20]  = 1'b0;
        for (int c = 0; c < 10; c++) begin
            cyc();
            tests++;
            if (bus.evt_valid !== 1'b0 || bus.pending !== 1'b1) begin
                fails++;
                $display("FAIL disabled c%0d: valid=%0b pending=%0b, want 0/1", c, bus.evt_valid, bus.pending);
            end
        end
        bus.enable = 1'b1;
        cyc();
        cyc();
        bus.evt_ready = 1'b0;
        cyc();
        tests++;
        if (bus.evt_valid !== 1'b1 || bus.evt_key !== KW'(20) || bus.evt_count !== CNT_W'(1)) begin
            fails++;
            $display("FAIL pre_rst_offer: valid=%0b key=%0d count=%0d, want 1/20/1",
                     bus.evt_valid, bus.evt_key, bus.evt_count);
        end
        #3;
        rst = 1'b1;
        #1;
        tests++;
        if (bus.evt_valid !== 1'b0 || bus.evt_count !== '0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL async_rst: valid=%0b count=%0d busy=%0b, want 0/0/0",
                     bus.evt_valid, bus.evt_count, bus.busy);
        end
        cyc();
        rst = 1'b0;
        cyc();
        tests++;
        if (bus.evt_valid !== 1'b1 || bus.evt_key !== KW'(10) || bus.evt_pressed !== 1'b1) begin
            fails++;
            $display("FAIL resume: valid=%0b key=%0d pressed=%0b, want 1/10/1",
                     bus.evt_valid, bus.evt_key, bus.evt_pressed);
        end
    endtask

    task automatic test_random();
        logic [KW+CNT_W+3:0] got;
        logic [KW+CNT_W+3:0] exp;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            cyc();
            got = {bus.evt_valid, bus.evt_key, bus.evt_pressed, bus.evt_count, bus.pending, bus.busy};
            exp = {m_valid, KW'(m_key), m_pressed, CNT_W'(m_cnt), |(bus.keys ^ m_rep), m_valid};
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL random c%0d: got=%h want=%h", c, got, exp);
            end
            bus.enable    = ($urandom_range(0, 9) != 0);
            bus.evt_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 2) == 0) begin
                int k;
                k = $urandom_range(0, KEYS - 1);
                bus.keys[k] = ~bus.keys[k];
            end
            if ($urandom_range(0, 99) == 0) bus.keys = bus.keys ^ {$urandom, $urandom};
        end
    endtask

    task automatic test_rr_pick();
        int w;
        for (int n = 0; n < 600; n++) begin
            pr_req = '0;
            case (n)
                0: begin pr_req = '0;                       pr_ptr = KW'(0);  end
                1: begin pr_req[0] = 1'b1;                  pr_ptr = KW'(60); end
                2: begin pr_req[0] = 1'b1; pr_req[60] = 1'b1; pr_ptr = KW'(60); end
                3: begin pr_req[60] = 1'b1;                 pr_ptr = KW'(0);  end
                4: begin pr_req = '1;                       pr_ptr = KW'(33); end
                default: begin
                    for (int b = 0; b < $urandom_range(0, 4); b++)
                        pr_req[$urandom_range(0, KEYS - 1)] = 1'b1;
                    pr_ptr = KW'($urandom_range(0, KEYS - 1));
                end
            endcase
            #1;
            w = ref_pick(pr_req, int'(pr_ptr));
            tests++;
            if (pr_any !== (w >= 0) || (w >= 0 && pr_idx !== KW'(w))) begin
                fails++;
                $display("FAIL rr_pick n%0d: any=%0b idx=%0d, want any=%0b idx=%0d (ptr=%0d)",
                         n, pr_any, pr_idx, (w >= 0), w, pr_ptr);
            end
        end
    endtask

    initial begin
        bus.keys      = '1;
        bus.enable    = 1'b1;
        bus.evt_ready = 1'b0;
        pr_req        = '0;
        pr_ptr        = '0;
        test_rr_pick();
        test_reset();
        test_single();
        test_back_to_back();
        test_wrap();
        test_hold();
        test_enable_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/key_event_scheduler.md
Name: key_event_scheduler

Overview:
- Sits between the debounced key vector and the USB/report logic.
- Compares the debounced levels against a register of the last reported level for each key.
- Picks one changed key per event with a round-robin arbiter and presents it as a press/release event on a valid/ready interface.
- No event is ever lost. A key that changes while it waits is reported at its level when it is granted. Later changes are picked up again.

Parameters:
- KEYS, 61, number of debounced key inputs.
- KEY_W, $clog2(KEYS), width of the key index (derived; not overridden).
- CNT_W, 16, width of the accepted-event counter.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  reset, asynchronous, active-high
- keys_i  input  KEYS  debounced key levels; 1 = released, 0 = pressed
- enable_i  input  1  allows new grants; an offer already in progress always completes
- evt_valid_o  output  1  event is presented
- evt_key_o  output  KEY_W  index of the granted key
- evt_pressed_o  output  1  1 = press (level 0), 0 = release (level 1)
- evt_ready_i  input  1  consumer accepts the event
- pending_o  output  1  OR of (keys_i XOR reported), combinational
- evt_count_o  output  CNT_W  number of accepted events, wraps at 2^CNT_W
- busy_o  output  1  state is OFFER

Behaviour:
- One clock, clk_i. rst_i is asynchronous and active-high.
- Reset values:
  - reported register = all ones (every key released).
  - rr pointer = 0, state = IDLE.
  - evt_valid_o = 0, evt_key_o = 0, evt_pressed_o = 0.
  - evt_count_o = 0, busy_o = 0.
- pending vector = keys_i XOR reported.
- Arbiter: the winner is the first set pending bit at or above the pointer, searching upward. If none is found there, search wraps from index 0. The arbiter is combinational.
- State IDLE:
  - If enable_i = 1 and pending is non-zero, on the next edge latch the winner index into evt_key_o and ~keys_i[winner] into evt_pressed_o.
  - On that same edge set evt_valid_o = 1 and go to OFFER.
  - Otherwise stay in IDLE with evt_valid_o = 0.
- State OFFER:
  - evt_valid_o, evt_key_o and evt_pressed_o stay constant until the handshake, whatever keys_i or enable_i do.
  - Handshake is evt_valid_o & evt_ready_i at a rising edge. On that edge:
    - reported[evt_key_o] <= ~evt_pressed_o.
    - pointer <= evt_key_o + 1, or 0 when evt_key_o = KEYS-1.
    - evt_count_o increments.
    - evt_valid_o <= 0, state <= IDLE.
- Latency: an event is valid 1 cycle after its pending bit is visible in IDLE. Maximum throughput is 1 event per 2 cycles.
- A key that flips back before it is granted has its pending bit cleared and produces no event.
- A key that flips during OFFER leaves the latched event unchanged. After acceptance its pending bit reflects the new level and it is re-arbitrated.
- Only one reported bit is updated per handshake. Other keys keep their pending bits.
- Keys already held when reset releases produce press events. This is intended.
- enable_i = 0 during OFFER does not withdraw the event.
- rst_i asserted mid-OFFER drops the event immediately (asynchronously) and returns all state to reset values.
- Pointer arithmetic is done in KEY_W bits and wraps explicitly at KEYS-1, not at 2^KEY_W.

Decomposition:
- Package key_pkg holds:
  - KEYS_DEFAULT = 61.
  - the KEY_W derivation function.
  - the state enum {IDLE, OFFER}.
  - the level constants KEY_PRESSED = 0 and KEY_RELEASED = 1.
- One sub-module, rr_pick: a combinational round-robin priority encoder.
  - Inputs: req[KEYS], ptr[KEY_W].
  - Outputs: any, idx[KEY_W].
  - Bench it standalone as well.

Test Plan:
- Reset with keys_i all ones -> evt_valid_o stays 0, pending_o = 0, evt_count_o = 0 for 20 cycles.
- Key 5 driven to 0, evt_ready_i = 1 -> one cycle later evt_valid_o = 1, evt_key_o = 5, evt_pressed_o = 1. Accepted, then evt_count_o = 1 and pending_o = 0. Key 5 returned to 1 -> release event with key 5, evt_pressed_o = 0.
- Keys 3, 40, 60 pressed in the same cycle, pointer 0, ready held high -> events in order 3, 40, 60, 2 cycles apart, then idle.
- Wrap: pointer at 60 after accepting key 59, then keys 0 and 60 pressed -> order 60, then 0.
- evt_ready_i = 0 for 10 cycles while key 7's event is offered, key 7 released in cycle 4 -> outputs stay key 7 press throughout. After ready, the next event is key 7 release.
- enable_i = 0 with keys pending -> no evt_valid_o. rst_i pulsed during an OFFER -> evt_valid_o drops within the same cycle and evt_count_o = 0. Events resume after rst_i falls.
